// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters using round-robin
// arbitration with valid/ready handshakes. The granted request drives the
// ALU inputs in the same cycle, and the ALU result and flags are captured
// into that requester's response register on the following clock edge.
//
// Ports:
//   CLK, nRST                     clock (rising edge), async active-low reset
//   reqN_valid/op/a/b             request from requester N (N = 0, 1)
//   reqN_ready                    request N accepted this cycle (grant)
//   rspN_valid/data/flags         response register N, flags = {neg, ovf, zero}
//   rspN_ready                    requester N consumes its response
//   alu_op/alu_a/alu_b            ALU inputs (zero when nothing is granted)
//   alu_out/alu_neg/ovf/zero      ALU result and flags
//   ops_issued                    count of accepted operations (wraps)
module alu_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,

   input  logic             req0_valid,
   input  logic [3:0]       req0_op,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   output logic             req0_ready,
   output logic             rsp0_valid,
   output logic [31:0]      rsp0_data,
   output logic [2:0]       rsp0_flags,
   input  logic             rsp0_ready,

   input  logic             req1_valid,
   input  logic [3:0]       req1_op,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   output logic             req1_ready,
   output logic             rsp1_valid,
   output logic [31:0]      rsp1_data,
   output logic [2:0]       rsp1_flags,
   input  logic             rsp1_ready,

   output logic [3:0]       alu_op,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   input  logic [31:0]      alu_out,
   input  logic             alu_neg,
   input  logic             alu_ovf,
   input  logic             alu_zero,

   output logic [CNT_W-1:0] ops_issued
);

   logic             rsp0_valid_q, rsp0_valid_d;
   logic [31:0]      rsp0_data_q,  rsp0_data_d;
   logic [2:0]       rsp0_flags_q, rsp0_flags_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [31:0]      rsp1_data_q,  rsp1_data_d;
   logic [2:0]       rsp1_flags_q, rsp1_flags_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] ops_issued_q, ops_issued_d;

   logic             free0, free1;
   logic             elig0, elig1;
   logic             grant0, grant1;
   logic [2:0]       alu_flags;

   assign alu_flags = {alu_neg, alu_ovf, alu_zero};

   // A slot is free when empty, or when its current response is being
   // consumed this cycle so it can be refilled without a bubble.
   assign free0 = !rsp0_valid_q || rsp0_ready;
   assign free1 = !rsp1_valid_q || rsp1_ready;
   assign elig0 = req0_valid && free0;
   assign elig1 = req1_valid && free1;

   // On contention the requester that did not win last time is granted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (elig0 && elig1) begin
         grant0 = last_grant_q;
         grant1 = !last_grant_q;
      end else begin
         grant0 = elig0;
         grant1 = elig1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      alu_op = '0;
      alu_a  = '0;
      alu_b  = '0;
      if (grant0) begin
         alu_op = req0_op;
         alu_a  = req0_a;
         alu_b  = req0_b;
      end else if (grant1) begin
         alu_op = req1_op;
         alu_a  = req1_a;
         alu_b  = req1_b;
      end
   end

   always_comb begin
      rsp0_valid_d = rsp0_valid_q;
      rsp0_data_d  = rsp0_data_q;
      rsp0_flags_d = rsp0_flags_q;
      if (grant0) begin
         rsp0_valid_d = 1'b1;
         rsp0_data_d  = alu_out;
         rsp0_flags_d = alu_flags;
      end else if (rsp0_ready) begin
         rsp0_valid_d = 1'b0;
      end
   end

   always_comb begin
      rsp1_valid_d = rsp1_valid_q;
      rsp1_data_d  = rsp1_data_q;
      rsp1_flags_d = rsp1_flags_q;
      if (grant1) begin
         rsp1_valid_d = 1'b1;
         rsp1_data_d  = alu_out;
         rsp1_flags_d = alu_flags;
      end else if (rsp1_ready) begin
         rsp1_valid_d = 1'b0;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      ops_issued_d = ops_issued_q;
      if (grant0 || grant1) begin
         last_grant_d = grant1;
         ops_issued_d = ops_issued_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rsp0_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp0_flags_q <= '0;
         rsp1_valid_q <= 1'b0;
         rsp1_data_q  <= '0;
         rsp1_flags_q <= '0;
         last_grant_q <= 1'b1;
         ops_issued_q <= '0;
      end else begin
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp0_flags_q <= rsp0_flags_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_data_q  <= rsp1_data_d;
         rsp1_flags_q <= rsp1_flags_d;
         last_grant_q <= last_grant_d;
         ops_issued_q <= ops_issued_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp0_flags = rsp0_flags_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_data  = rsp1_data_q;
   assign rsp1_flags = rsp1_flags_q;
   assign ops_issued = ops_issued_q;

endmodule
